multi_tick_divider: RTL and testbench
=====================================

MULTI_TICK_DIVIDER -- requirements
Module: multi_tick_divider

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter CNT_W, default 32: counter and divisor width, 8..32.
REQ-003 Parameter DEFAULT_DIV, default 50_000_000: divisor loaded into every channel at reset.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 enable  input  NUM_CH  per-channel count enable, level.
REQ-007 start  input  NUM_CH  per-channel one-cycle pulse that arms a one-shot channel.
REQ-008 sync_restart  input  1  one-cycle pulse that realigns all channels.
REQ-009 cfg_wr  input  1  one-cycle config write strobe.
REQ-010 cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel of cfg_wr.
REQ-011 cfg_div  input  CNT_W  new divisor for cfg_ch.
REQ-012 cfg_oneshot  input  1  new mode for cfg_ch: 1 = one-shot, 0 = periodic.
REQ-013 divided_clk  output  NUM_CH  per-channel registered square output, toggles on each terminal count.
REQ-014 tick  output  NUM_CH  per-channel registered one-cycle pulse per terminal count.
REQ-015 beat  output  NUM_CH  per-channel registered pulse: tick qualified by divided_clk high before the toggle.
REQ-016 busy  output  NUM_CH  per-channel flag: channel armed and counting.

Function
REQ-017 Effective divisor div_eff = max(div_reg, 1); div_reg of 0 SHALL behave as 1.
REQ-018 Armed channel with enable=1 SHALL increment its counter each cycle; with enable=0 the counter SHALL hold.
REQ-019 Terminal cycle: channel armed, enable=1 and counter >= div_eff-1; the counter SHALL load 0 on the next edge. The >= compare covers a counter above a newly reduced divisor.
REQ-020 On a terminal cycle, tick SHALL be 1 for exactly the following cycle and divided_clk SHALL invert on the same edge. Latency: terminal cycle to tick = 1 clk.
REQ-021 beat SHALL be 1 in the same cycle as tick, only if divided_clk was 1 during the terminal cycle. beat therefore pulses once per two ticks.
REQ-022 Periodic mode: the channel SHALL stay armed permanently.
REQ-023 One-shot mode: after its terminal cycle, the channel SHALL disarm (busy=0) and hold the counter at 0.
REQ-024 One-shot mode: a start pulse SHALL re-arm the channel. start on an armed or periodic channel SHALL be ignored.
REQ-025 cfg_wr SHALL load div_reg and the mode for cfg_ch, clear that counter to 0, and arm the channel. divided_clk SHALL keep its value.
REQ-026 cfg_ch >= NUM_CH SHALL make cfg_wr a no-op.
REQ-027 sync_restart SHALL clear all counters and divided_clk to 0 and arm every channel. No tick or beat SHALL fire in that cycle.
REQ-028 Priority per channel: sync_restart > cfg_wr (to that channel) > start > counting. A suppressed terminal cycle SHALL produce no tick.
REQ-029 div_eff = 1 with enable held high: tick SHALL be 1 every cycle and divided_clk SHALL toggle every cycle.
REQ-030 Channels SHALL be fully independent apart from the shared cfg bus and sync_restart.

Reset
REQ-031 While reset_n = 0: counters = 0, div_reg = DEFAULT_DIV, mode = periodic, all channels armed (busy = all ones), divided_clk = 0, tick = 0, beat = 0.
REQ-032 Assertion SHALL take effect immediately, regardless of clk; mid-count state SHALL be discarded.
REQ-033 Counting SHALL start on the first rising edge after reset_n goes high.

Structure
REQ-034 Shared package tick_div_pkg SHALL hold the mode enum (MODE_PERIODIC, MODE_ONESHOT) and the limits NUM_CH_MAX = 16 and CNT_W_MAX = 32.
REQ-035 Per-channel logic SHALL live in sub-module tick_div_channel, generated NUM_CH times.
REQ-036 The top level SHALL only decode cfg_ch and fan out sync_restart.

Verification
REQ-037 DEFAULT_DIV=4, NUM_CH=2, enable=11 after reset -> tick every 4 clks on both channels; divided_clk period 8 clks; beat on every second tick.
REQ-038 cfg_wr ch1 div=3 one-shot, enable=1 -> exactly one tick 3 clks later, then busy[1]=0 and no more ticks. start[1] pulse -> one more tick 3 clks later.
REQ-039 Counter at 9 with div=20; cfg_wr same channel div=5 -> counter clears, next tick 5 clks after the write, divided_clk unchanged by the write.
REQ-040 cfg_wr and a terminal cycle on the same channel in the same cycle -> no tick; counter = 0. sync_restart together with cfg_wr -> all counters 0, divided_clk all 0, new div_reg still written.
REQ-041 cfg_div=0 and cfg_div=1 -> tick high every enabled cycle. enable dropped for 3 clks mid-count -> tick delayed by exactly 3 clks.
REQ-042 reset_n pulsed low between clk edges mid-count -> outputs clear at once; after release the first tick comes DEFAULT_DIV clks later.

Source files
------------

// File: rtl/multi_tick_divider_pkg.sv
// tick_div_pkg: definitions shared by the multi-channel tick divider.
//   mode_e       - channel mode: periodic (always armed) or one-shot
//   NUM_CH_MAX   - upper bound on the channel count
//   CNT_W_MAX    - upper bound on the counter/divisor width
//   eff_div()    - maps a stored divisor to the divisor actually used (0 acts as 1)
package tick_div_pkg;

  localparam int NUM_CH_MAX = 16;
  localparam int CNT_W_MAX  = 32;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  function automatic logic [CNT_W_MAX-1:0] eff_div(input logic [CNT_W_MAX-1:0] div);
    return (div == '0) ? CNT_W_MAX'(1) : div;
  endfunction

endpackage

// File: rtl/multi_tick_divider_if.sv
// multi_tick_divider_if: configuration bus for the tick divider.
//   cfg_wr       - one-cycle write strobe
//   cfg_ch       - target channel (writes to a channel >= NUM_CH are dropped)
//   cfg_div      - new divisor
//   cfg_oneshot  - new mode, 1 = one-shot, 0 = periodic
// master drives the bus, slave (the divider) receives it.
interface multi_tick_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_oneshot;

  modport master (output cfg_wr, cfg_ch, cfg_div, cfg_oneshot);
  modport slave  (input  cfg_wr, cfg_ch, cfg_div, cfg_oneshot);

endinterface

// File: rtl/multi_tick_divider_channel.sv
// tick_div_channel: one independent divider channel.
//   clk, reset_n   - clock, asynchronous active-low reset
//   enable         - count enable (level)
//   start          - re-arms a disarmed one-shot channel
//   sync_restart   - clears counter and divided_clk, arms the channel
//   cfg_hit        - configuration write addressed to this channel
//   cfg_div        - divisor loaded by cfg_hit
//   cfg_oneshot    - mode loaded by cfg_hit
//   divided_clk    - square output, toggles on every terminal count
//   tick           - one-cycle pulse following each terminal cycle
//   beat           - tick qualified by divided_clk being high before the toggle
//   busy           - channel armed
module tick_div_channel
  import tick_div_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic             sync_restart,
  input  logic             cfg_hit,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_oneshot,
  output logic             divided_clk,
  output logic             tick,
  output logic             beat,
  output logic             busy
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] div_q,   div_d;
  mode_e            mode_q,  mode_d;
  logic             armed_q, armed_d;
  logic             dclk_q,  dclk_d;
  logic             tick_q,  tick_d;
  logic             beat_q,  beat_d;

  logic [CNT_W-1:0] div_eff;
  logic             terminal;

  assign div_eff = CNT_W'(eff_div(CNT_W_MAX'(div_q)));

  // >= rather than == so a counter already past a freshly lowered divisor
  // still wraps on its next enabled cycle.
  assign terminal = armed_q && enable && (cnt_q >= (div_eff - CNT_W'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      div_q   <= DIV_RST;
      mode_q  <= MODE_PERIODIC;
      armed_q <= 1'b1;
      dclk_q  <= 1'b0;
      tick_q  <= 1'b0;
      beat_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      armed_q <= armed_d;
      dclk_q  <= dclk_d;
      tick_q  <= tick_d;
      beat_q  <= beat_d;
    end
  end

  // Priority: sync_restart > cfg write > start > counting. Any branch above
  // counting swallows a coincident terminal cycle, so no tick escapes.
  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    mode_d  = mode_q;
    armed_d = armed_q;
    dclk_d  = dclk_q;
    tick_d  = 1'b0;
    beat_d  = 1'b0;

    // The configuration is stored even when sync_restart wins the cycle.
    if (cfg_hit) begin
      div_d  = cfg_div;
      mode_d = cfg_oneshot ? MODE_ONESHOT : MODE_PERIODIC;
    end

    if (sync_restart) begin
      cnt_d   = '0;
      dclk_d  = 1'b0;
      armed_d = 1'b1;
    end else if (cfg_hit) begin
      // divided_clk deliberately keeps its phase across a reconfiguration.
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (start && (mode_q == MODE_ONESHOT) && !armed_q) begin
      armed_d = 1'b1;
    end else if (terminal) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      beat_d = dclk_q;
      dclk_d = ~dclk_q;
      if (mode_q == MODE_ONESHOT) begin
        armed_d = 1'b0;
      end
    end else if (armed_q && enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign divided_clk = dclk_q;
  assign tick        = tick_q;
  assign beat        = beat_q;
  assign busy        = armed_q;

endmodule

// File: rtl/multi_tick_divider.sv
// multi_tick_divider: NUM_CH independent programmable tick dividers.
//   clk, reset_n   - clock, asynchronous active-low reset
//   enable[ch]     - per-channel count enable
//   start[ch]      - per-channel one-shot re-arm pulse
//   sync_restart   - realigns every channel (counters and divided_clk to 0)
//   cfg_if         - configuration bus (write strobe, channel, divisor, mode)
//   divided_clk    - per-channel square output
//   tick, beat     - per-channel terminal-count pulses
//   busy           - per-channel armed flag
// The top only decodes the configuration target and fans out sync_restart.
module multi_tick_divider
  import tick_div_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_CH-1:0]   enable,
  input  logic [NUM_CH-1:0]   start,
  input  logic                sync_restart,
  multi_tick_divider_if.slave cfg_if,
  output logic [NUM_CH-1:0]   divided_clk,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   beat,
  output logic [NUM_CH-1:0]   busy
);

  logic [NUM_CH-1:0] cfg_hit;

  // Out-of-range channel numbers match no channel, so such writes vanish.
  always_comb begin
    cfg_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_hit[i] = cfg_if.cfg_wr && (int'(cfg_if.cfg_ch) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable[g]),
      .start        (start[g]),
      .sync_restart (sync_restart),
      .cfg_hit      (cfg_hit[g]),
      .cfg_div      (cfg_if.cfg_div),
      .cfg_oneshot  (cfg_if.cfg_oneshot),
      .divided_clk  (divided_clk[g]),
      .tick         (tick[g]),
      .beat         (beat[g]),
      .busy         (busy[g])
    );
  end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Testbench for multi_tick_divider: directed vector table, hand-written
// corner sequences and random traffic against a behavioural model.
module tb_multi_tick_divider;
  import tick_div_pkg::*;

  localparam int NCH  = 3;
  localparam int CW   = 8;
  localparam int DDIV = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NCH-1:0] enable = '0;
  logic [NCH-1:0] start = '0;
  logic sync_restart = 1'b0;
  logic [NCH-1:0] divided_clk, tick, beat, busy;

  multi_tick_divider_if #(.NUM_CH(NCH), .CNT_W(CW)) cfg_bus ();

  multi_tick_divider #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .start        (start),
    .sync_restart (sync_restart),
    .cfg_if       (cfg_bus),
    .divided_clk  (divided_clk),
    .tick         (tick),
    .beat         (beat),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer counters per channel, updated once per edge.
  int             m_cnt [NCH];
  int             m_div [NCH];
  logic [NCH-1:0] m_os, m_arm, m_dclk, m_tick, m_beat;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0;
      m_div[c] = DDIV;
    end
    m_os = '0; m_arm = '1; m_dclk = '0; m_tick = '0; m_beat = '0;
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      bit hit;
      int effd;
      hit  = cfg_bus.cfg_wr && (int'(cfg_bus.cfg_ch) == c);
      effd = (m_div[c] == 0) ? 1 : m_div[c];
      m_tick[c] = 1'b0;
      m_beat[c] = 1'b0;
      if (sync_restart) begin
        m_cnt[c] = 0; m_dclk[c] = 1'b0; m_arm[c] = 1'b1;
      end else if (hit) begin
        m_cnt[c] = 0; m_arm[c] = 1'b1;
      end else if (start[c] && m_os[c] && !m_arm[c]) begin
        m_arm[c] = 1'b1;
      end else if (m_arm[c] && enable[c]) begin
        if (m_cnt[c] + 1 >= effd) begin
          m_tick[c] = 1'b1;
          m_beat[c] = m_dclk[c];
          m_dclk[c] = ~m_dclk[c];
          m_cnt[c]  = 0;
          if (m_os[c]) m_arm[c] = 1'b0;
        end else begin
          m_cnt[c]++;
        end
      end
      if (hit) begin
        m_div[c] = int'(cfg_bus.cfg_div);
        m_os[c]  = cfg_bus.cfg_oneshot;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model", 32'({divided_clk, tick, beat, busy}), 32'({m_dclk, m_tick, m_beat, m_arm}));
  endtask

  task automatic do_cfg(input int ch, input int div, input bit os);
    cfg_bus.cfg_wr = 1'b1;
    cfg_bus.cfg_ch = 2'(ch);
    cfg_bus.cfg_div = CW'(div);
    cfg_bus.cfg_oneshot = os;
    step();
    cfg_bus.cfg_wr = 1'b0;
  endtask

  // Steps until tick[ch] is seen; lat = edges taken, or max if none came.
  task automatic wait_tick(input int ch, input int max, output int lat);
    lat = max;
    for (int k = 1; k <= max; k++) begin
      step();
      if (tick[ch]) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [NCH-1:0] st;
    logic           wr;
    int             ch;
    int             div;
    logic           os;
    logic [NCH-1:0] e_tick;
    logic [NCH-1:0] e_beat;
    logic [NCH-1:0] e_dclk;
    logic [NCH-1:0] e_busy;
  } vec_t;

  vec_t vt [20];

  initial begin
    int lat;
    logic d0;

    // Reset release, all channels enabled, DEFAULT_DIV=4.
    vt[0]  = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111};
    vt[1]  = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111};
    vt[2]  = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111};
    vt[3]  = '{3'b000, 0, 0, 0, 0, 3'b111, 3'b000, 3'b111, 3'b111};
    vt[4]  = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 3'b111};
    vt[5]  = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 3'b111};
    vt[6]  = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 3'b111};
    vt[7]  = '{3'b000, 0, 0, 0, 0, 3'b111, 3'b111, 3'b000, 3'b111};
    // ch1 -> one-shot, div 3.
    vt[8]  = '{3'b000, 1, 1, 3, 1, 3'b000, 3'b000, 3'b000, 3'b111};
    vt[9]  = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111};
    vt[10] = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b111};
    vt[11] = '{3'b000, 0, 0, 0, 0, 3'b111, 3'b000, 3'b111, 3'b101};
    vt[12] = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 3'b101};
    vt[13] = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 3'b101};
    vt[14] = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b111, 3'b101};
    vt[15] = '{3'b000, 0, 0, 0, 0, 3'b101, 3'b101, 3'b010, 3'b101};
    // start on ch1 (one-shot, idle) and ch0 (periodic, ignored).
    vt[16] = '{3'b011, 0, 0, 0, 0, 3'b000, 3'b000, 3'b010, 3'b111};
    vt[17] = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b010, 3'b111};
    vt[18] = '{3'b000, 0, 0, 0, 0, 3'b000, 3'b000, 3'b010, 3'b111};
    vt[19] = '{3'b000, 0, 0, 0, 0, 3'b111, 3'b010, 3'b101, 3'b101};

    cfg_bus.cfg_wr = 1'b0;
    cfg_bus.cfg_ch = '0;
    cfg_bus.cfg_div = '0;
    cfg_bus.cfg_oneshot = 1'b0;
    model_reset();

    #12;
    check("reset_state", 32'({divided_clk, tick, beat, busy}), 32'({3'b000, 3'b000, 3'b000, 3'b111}));
    enable = '1;
    #10;
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      start = vt[i].st;
      cfg_bus.cfg_wr = vt[i].wr;
      cfg_bus.cfg_ch = 2'(vt[i].ch);
      cfg_bus.cfg_div = CW'(vt[i].div);
      cfg_bus.cfg_oneshot = vt[i].os;
      step();
      check($sformatf("vec%0d", i), 32'({divided_clk, tick, beat, busy}),
            32'({vt[i].e_dclk, vt[i].e_tick, vt[i].e_beat, vt[i].e_busy}));
    end
    start = '0;
    cfg_bus.cfg_wr = 1'b0;

    // Divisor lowered below the running count.
    do_cfg(0, 20, 0);
    for (int k = 0; k < 9; k++) step();
    d0 = m_dclk[0];
    do_cfg(0, 5, 0);
    check("cfg_keeps_dclk", 32'(divided_clk[0]), 32'(d0));
    wait_tick(0, 30, lat);
    check("lat_after_shrink", lat, 5);

    // Write on the terminal cycle swallows the tick.
    do_cfg(2, 3, 0);
    step();
    step();
    do_cfg(2, 3, 0);
    check("cfg_over_terminal", 32'(tick[2]), 0);
    wait_tick(2, 10, lat);
    check("lat_after_rewrite", lat, 3);

    // sync_restart together with a write.
    cfg_bus.cfg_wr = 1'b1; cfg_bus.cfg_ch = 2'd1; cfg_bus.cfg_div = CW'(2); cfg_bus.cfg_oneshot = 1'b0;
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    cfg_bus.cfg_wr = 1'b0;
    check("sync_clears", 32'({divided_clk, tick, beat}), 0);
    check("sync_arms", 32'(busy), 32'(3'b111));
    wait_tick(1, 10, lat);
    check("sync_div_written", lat, 2);

    // Divisor 0 and 1 tick every enabled cycle.
    do_cfg(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("div0_tick", 32'(tick[0]), 1);
    end
    do_cfg(0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("div1_tick", 32'(tick[0]), 1);
    end

    // Enable gap of 3 clocks delays the tick by 3.
    do_cfg(0, 6, 0);
    step();
    step();
    enable[0] = 1'b0;
    for (int k = 0; k < 3; k++) step();
    enable[0] = 1'b1;
    wait_tick(0, 20, lat);
    check("enable_gap", 5 + lat, 9);

    // Out-of-range channel write is ignored.
    do_cfg(3, 1, 1);
    for (int k = 0; k < 8; k++) step();

    // Asynchronous reset between edges.
    for (int k = 0; k < 2; k++) step();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", 32'({divided_clk, tick, beat, busy}), 32'({3'b000, 3'b000, 3'b000, 3'b111}));
    step();
    @(negedge clk);
    reset_n = 1'b1;
    wait_tick(0, 20, lat);
    check("lat_after_reset", lat, DDIV);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      enable = NCH'($urandom);
      start = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      sync_restart = ($urandom_range(0, 39) == 0);
      cfg_bus.cfg_wr = ($urandom_range(0, 7) == 0);
      cfg_bus.cfg_ch = 2'($urandom_range(0, 3));
      cfg_bus.cfg_div = CW'($urandom_range(0, 9));
      cfg_bus.cfg_oneshot = 1'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
